// File: rtl/rhd_seq_pkg.sv
// Shared constants, command encoding and FSM state type for the RHD command sequencer.
// Build option RHD_AUX_CMD_EN is handled in rhd_cmd_sequencer; nothing here depends on it.
package rhd_seq_pkg;

  localparam int CMD_CH_W = 6;

  localparam logic [1:0]          CMD_CONVERT = 2'b00;
  localparam logic [CMD_CH_W-1:0] CMD_AUX_TAG = 6'h3F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_HI,
    ST_WAIT_LO
  } seq_state_e;

  function automatic logic [31:0] convert_cmd(input logic [CMD_CH_W-1:0] ch);
    return {CMD_CONVERT, ch, 24'h000000};
  endfunction

endpackage

// File: rtl/rhd_tag_pipe.sv
// Channel-tag delay line: one entry pushed per issued frame; the tail is the tag of the
// frame whose result the chip returns in the frame now being issued.
module rhd_tag_pipe #(
  parameter int DEPTH = 2,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         push_i,
  input  logic [W-1:0] tag_i,
  output logic [W-1:0] tail_o
);

  logic [W-1:0] stage_q [DEPTH];

  // NOTE: this is a handful of flops rather than a RAM, so resetting every entry is cheap and
  // keeps the tail deterministic; a real memory array would be left unreset instead.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else if (push_i) begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tail_o = stage_q[DEPTH-1];

endmodule

// File: rtl/rhd_cmd_sequencer.sv
// Sweeps CONVERT commands over NUM_CH channels through rhd_spi_master and streams re-tagged
// results downstream. Define RHD_AUX_CMD_EN to add one auxiliary command frame per sweep.
module rhd_cmd_sequencer
  import rhd_seq_pkg::*;
#(
  parameter int NUM_CH   = 32,
  parameter int CH_W     = 6,
  parameter int PIPE_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  output logic            spi_start,
  output logic [31:0]     spi_cmd,
  input  logic            spi_done,
  input  logic [31:0]     spi_result,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [31:0]     m_data,
  output logic [CH_W-1:0] m_channel,
  output logic            m_sof,
  output logic            overrun,
  input  logic            overrun_clr
`ifdef RHD_AUX_CMD_EN
  ,
  input  logic [31:0]     aux_cmd,
  input  logic            aux_valid,
  output logic            aux_ack
`endif
);

  localparam int                 PRIME_W    = $clog2(PIPE_LAT + 1);
  localparam logic [PRIME_W-1:0] PRIME_INIT = PRIME_W'(PIPE_LAT);
  localparam logic [CH_W-1:0]    LAST_IDX   = CH_W'(NUM_CH - 1);

  seq_state_e         state_q, state_d;
  logic [CH_W-1:0]    idx_q, idx_d;
  logic [PRIME_W-1:0] prime_q, prime_d;
  logic               aux_frame_q, aux_frame_d;
  logic [31:0]        spi_cmd_q, spi_cmd_d;
  logic [CH_W-1:0]    res_tag_q, res_tag_d;
  logic               m_valid_q, m_valid_d;
  logic [31:0]        m_data_q, m_data_d;
  logic [CH_W-1:0]    m_channel_q, m_channel_d;
  logic               m_sof_q, m_sof_d;
  logic               overrun_q, overrun_d;

  logic               pipe_push, pipe_clear, capture, overrun_set;
  logic [CH_W-1:0]    issue_tag, pipe_tail;
  logic               aux_req;
  logic [31:0]        aux_cmd_w;

`ifdef RHD_AUX_CMD_EN
  assign aux_req   = aux_valid;
  assign aux_cmd_w = aux_cmd;
  assign aux_ack   = (state_q == ST_ISSUE) && aux_frame_q;
`else
  assign aux_req   = 1'b0;
  assign aux_cmd_w = '0;
`endif

  assign issue_tag = aux_frame_q ? CH_W'(CMD_AUX_TAG) : idx_q;

  rhd_tag_pipe #(
    .DEPTH (PIPE_LAT),
    .W     (CH_W)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .clear_i (pipe_clear),
    .push_i  (pipe_push),
    .tag_i   (issue_tag),
    .tail_o  (pipe_tail)
  );

  // NOTE: every variable is given its hold value before the case statement, so no path through
  // this block leaves one unassigned and no latch can be inferred.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    prime_d     = prime_q;
    aux_frame_d = aux_frame_q;
    spi_cmd_d   = spi_cmd_q;
    res_tag_d   = res_tag_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_channel_d = m_channel_q;
    m_sof_d     = m_sof_q;
    overrun_d   = overrun_q;
    pipe_push   = 1'b0;
    pipe_clear  = 1'b0;
    capture     = 1'b0;
    overrun_set = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        // The tail is read before this push lands: it names the frame answered in this frame.
        pipe_push = 1'b1;
        res_tag_d = pipe_tail;
        state_d   = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (spi_done) begin
          capture = 1'b1;
          state_d = ST_WAIT_LO;
        end
      end
      ST_WAIT_LO: begin
        if (!spi_done) begin
          if (aux_frame_q) begin
            aux_frame_d = 1'b0;
          end else if (idx_q == LAST_IDX) begin
            idx_d       = '0;
            aux_frame_d = aux_req;
          end else begin
            idx_d = idx_q + CH_W'(1);
          end
          if (enable) begin
            state_d = ST_ISSUE;
          end else begin
            state_d     = ST_IDLE;
            idx_d       = '0;
            aux_frame_d = 1'b0;
            prime_d     = PRIME_INIT;
            pipe_clear  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The command is loaded on entry so it is already valid during the start pulse.
    if (state_d == ST_ISSUE && state_q != ST_ISSUE) begin
      spi_cmd_d = aux_frame_d ? aux_cmd_w : convert_cmd(idx_d);
    end

    if (m_valid_q && m_ready) m_valid_d = 1'b0;

    if (capture) begin
      if (prime_q != '0) begin
        prime_d = prime_q - PRIME_W'(1);
      end else if (m_valid_q && !m_ready) begin
        overrun_set = 1'b1;
      end else begin
        m_valid_d   = 1'b1;
        m_data_d    = spi_result;
        m_channel_d = res_tag_q;
        m_sof_d     = (res_tag_q == '0);
      end
    end

    if (overrun_clr) overrun_d = 1'b0;
    if (overrun_set) overrun_d = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the values from
  // before this edge, regardless of the order the simulator evaluates processes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      prime_q     <= PRIME_INIT;
      aux_frame_q <= 1'b0;
      spi_cmd_q   <= '0;
      res_tag_q   <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_channel_q <= '0;
      m_sof_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      prime_q     <= prime_d;
      aux_frame_q <= aux_frame_d;
      spi_cmd_q   <= spi_cmd_d;
      res_tag_q   <= res_tag_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_channel_q <= m_channel_d;
      m_sof_q     <= m_sof_d;
      overrun_q   <= overrun_d;
    end
  end

  assign spi_start = (state_q == ST_ISSUE);
  assign spi_cmd   = spi_cmd_q;
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_channel = m_channel_q;
  assign m_sof     = m_sof_q;
  assign overrun   = overrun_q;

endmodule
